// File: rtl/axi_ad9361_rx_delay_tune_pkg.sv
// Shared definitions for the AD9361 RX IDELAY sweep: FSM state encoding and
// the width helper for the combined settle/dwell counter.
package axi_ad9361_rx_delay_tune_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CLEAR  = 3'd3;
  localparam logic [2:0] ST_DWELL  = 3'd4;
  localparam logic [2:0] ST_EVAL   = 3'd5;
  localparam logic [2:0] ST_APPLY  = 3'd6;
  localparam logic [2:0] ST_DONE   = 3'd7;

  // One extra bit over clog2 so a power-of-two cycle count still fits.
  function automatic int cnt_width(input int settle, input int dwell);
    int longest;
    longest = (settle > dwell) ? settle : dwell;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/axi_ad9361_rx_tune_window.sv
// Longest error-free tap run tracker. The earliest window wins ties; the centre
// is the floor midpoint of the best window.
module axi_ad9361_rx_tune_window
  import axi_ad9361_rx_delay_tune_pkg::*;
#(
  parameter int TAP_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 eval,
  input  logic                 pass,
  input  logic [TAP_WIDTH-1:0] tap,
  output logic [TAP_WIDTH-1:0] best_start,
  output logic [TAP_WIDTH:0]   best_len,
  output logic [TAP_WIDTH-1:0] centre
);

  logic [TAP_WIDTH-1:0] cur_start_q, cur_start_d;
  logic [TAP_WIDTH:0]   cur_len_q, cur_len_d;
  logic [TAP_WIDTH-1:0] best_start_q, best_start_d;
  logic [TAP_WIDTH:0]   best_len_q, best_len_d;
  logic [TAP_WIDTH:0]   len_m1;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clr) begin
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (eval) begin
      if (pass) begin
        cur_len_d = cur_len_q + (TAP_WIDTH+1)'(1);
        if (cur_len_q == '0) cur_start_d = tap;
        if (cur_len_d > best_len_q) begin
          best_len_d   = cur_len_d;
          best_start_d = cur_start_d;
        end
      end else begin
        cur_len_d = '0;
      end
    end
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign len_m1     = best_len_q - (TAP_WIDTH+1)'(1);
  assign best_start = best_start_q;
  assign best_len   = best_len_q;
  assign centre     = TAP_WIDTH'({1'b0, best_start_q} + (len_m1 >> 1));

endmodule

// File: rtl/axi_ad9361_rx_delay_tune.sv
// Hardware IDELAY eye sweep for the AD9361 RX interface: steps a common tap over
// the masked lanes, dwells on PN status per tap and loads the best window centre.
module axi_ad9361_rx_delay_tune
  import axi_ad9361_rx_delay_tune_pkg::*;
#(
  parameter int NUM_LANES     = 13,
  parameter int TAP_WIDTH     = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int DWELL_CYCLES  = 1024,
  parameter int MIN_WINDOW    = 4
) (
  input  logic                           up_clk,
  input  logic                           up_rstn,
  input  logic                           start,
  input  logic [NUM_LANES-1:0]           lane_mask,
  input  logic                           delay_locked,
  input  logic [NUM_LANES*TAP_WIDTH-1:0] up_drdata,
  input  logic                           pn_err,
  input  logic                           pn_oos,
  output logic                           pn_clr,
  output logic [NUM_LANES-1:0]           up_dld,
  output logic [NUM_LANES*TAP_WIDTH-1:0] up_dwdata,
  output logic                           busy,
  output logic                           done,
  output logic                           fail,
  output logic                           lock_err,
  output logic [TAP_WIDTH-1:0]           result_tap,
  output logic [TAP_WIDTH:0]             result_len
);

  localparam int BUS_W = NUM_LANES * TAP_WIDTH;
  localparam int CNT_W = cnt_width(SETTLE_CYCLES, DWELL_CYCLES);
  localparam logic [TAP_WIDTH-1:0] MAX_TAP = '1;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAP_WIDTH-1:0] tap_q, tap_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [BUS_W-1:0]     orig_q, orig_d;
  logic                 tap_bad_q, tap_bad_d;

  logic                 pn_clr_q, pn_clr_d;
  logic [NUM_LANES-1:0] up_dld_q, up_dld_d;
  logic [BUS_W-1:0]     up_dwdata_q, up_dwdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 lock_err_q, lock_err_d;
  logic [TAP_WIDTH-1:0] result_tap_q, result_tap_d;
  logic [TAP_WIDTH:0]   result_len_q, result_len_d;

  logic                 win_clr, win_eval;
  logic [TAP_WIDTH:0]   best_len;
  logic [TAP_WIDTH-1:0] centre;
  logic                 in_sweep, success;
  logic                 load_en, load_orig_only;
  logic [TAP_WIDTH-1:0] load_tap;

  axi_ad9361_rx_tune_window #(
    .TAP_WIDTH (TAP_WIDTH)
  ) u_window (
    .clk        (up_clk),
    .rst_n      (up_rstn),
    .clr        (win_clr),
    .eval       (win_eval),
    .pass       (!tap_bad_q),
    .tap        (tap_q),
    .best_start (),
    .best_len   (best_len),
    .centre     (centre)
  );

  assign in_sweep = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_CLEAR) ||
                    (state_q == ST_DWELL) || (state_q == ST_EVAL);
  // A lock loss during the sweep forces failure regardless of the window found.
  assign success  = !lock_err_q && (best_len >= (TAP_WIDTH+1)'(MIN_WINDOW));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    tap_d          = tap_q;
    mask_d         = mask_q;
    orig_d         = orig_q;
    tap_bad_d      = tap_bad_q;
    busy_d         = busy_q;
    fail_d         = fail_q;
    lock_err_d     = lock_err_q;
    result_tap_d   = result_tap_q;
    result_len_d   = result_len_q;
    pn_clr_d       = 1'b0;
    up_dld_d       = '0;
    up_dwdata_d    = '0;
    done_d         = 1'b0;
    win_clr        = 1'b0;
    win_eval       = 1'b0;
    load_en        = 1'b0;
    load_orig_only = 1'b0;
    load_tap       = tap_q;

    if (done_q) busy_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !busy_q) begin
          mask_d       = lane_mask;
          orig_d       = up_drdata;
          tap_d        = '0;
          tap_bad_d    = 1'b0;
          win_clr      = 1'b1;
          busy_d       = 1'b1;
          fail_d       = 1'b0;
          lock_err_d   = 1'b0;
          result_tap_d = '0;
          result_len_d = '0;
          if (!delay_locked) begin
            fail_d     = 1'b1;
            lock_err_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        load_en = 1'b1;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_CLEAR;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CLEAR: begin
        pn_clr_d  = 1'b1;
        tap_bad_d = 1'b0;
        cnt_d     = CNT_W'(DWELL_CYCLES - 1);
        state_d   = ST_DWELL;
      end
      ST_DWELL: begin
        tap_bad_d = tap_bad_q | pn_err | pn_oos;
        if (cnt_q == '0) state_d = ST_EVAL;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_EVAL: begin
        win_eval = 1'b1;
        if (tap_q == MAX_TAP) begin
          state_d = ST_APPLY;
        end else begin
          tap_d   = tap_q + TAP_WIDTH'(1);
          state_d = ST_LOAD;
        end
      end
      ST_APPLY: begin
        load_en      = 1'b1;
        result_len_d = best_len;
        if (success) begin
          load_tap     = centre;
          result_tap_d = centre;
          fail_d       = 1'b0;
        end else begin
          load_orig_only = 1'b1;
          result_tap_d   = '0;
          fail_d         = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_sweep && !delay_locked) begin
      lock_err_d = 1'b1;
      state_d    = ST_APPLY;
    end

    // Unmasked lanes always carry their pre-sweep value on the shared bus.
    if (load_en) begin
      up_dld_d = mask_q;
      for (int i = 0; i < NUM_LANES; i++) begin
        up_dwdata_d[i*TAP_WIDTH +: TAP_WIDTH] = (mask_q[i] && !load_orig_only) ?
                                                load_tap : orig_q[i*TAP_WIDTH +: TAP_WIDTH];
      end
    end
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      mask_q       <= '0;
      orig_q       <= '0;
      tap_bad_q    <= 1'b0;
      pn_clr_q     <= 1'b0;
      up_dld_q     <= '0;
      up_dwdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lock_err_q   <= 1'b0;
      result_tap_q <= '0;
      result_len_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      mask_q       <= mask_d;
      orig_q       <= orig_d;
      tap_bad_q    <= tap_bad_d;
      pn_clr_q     <= pn_clr_d;
      up_dld_q     <= up_dld_d;
      up_dwdata_q  <= up_dwdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      lock_err_q   <= lock_err_d;
      result_tap_q <= result_tap_d;
      result_len_q <= result_len_d;
    end
  end

  assign pn_clr     = pn_clr_q;
  assign up_dld     = up_dld_q;
  assign up_dwdata  = up_dwdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign lock_err   = lock_err_q;
  assign result_tap = result_tap_q;
  assign result_len = result_len_q;

endmodule

// File: tb/tb_axi_ad9361_rx_delay_tune.sv
// Self-checking bench for axi_ad9361_rx_delay_tune: a delay-line/PN model drives
// pn_err/pn_oos from the applied tap, and a brute-force window search predicts results.
module tb_axi_ad9361_rx_delay_tune;

  localparam int NL = 13;
  localparam int TW = 5;
  localparam int NT = 32;
  localparam int BW = NL * TW;
  localparam int SWEEP_CYC = NT * 15 + 3;

  logic          clk = 1'b0;
  logic          up_rstn = 1'b0;
  logic          start = 1'b0;
  logic [NL-1:0] lane_mask = '0;
  logic          delay_locked = 1'b1;
  logic [BW-1:0] up_drdata = '0;
  logic          pn_err, pn_oos;
  logic          pn_clr;
  logic [NL-1:0] up_dld;
  logic [BW-1:0] up_dwdata;
  logic          busy, done, fail, lock_err;
  logic [TW-1:0] result_tap;
  logic [TW:0]   result_len;

  bit            err_pat [NT];
  bit            oos_pat [NT];
  logic [TW-1:0] lane_tap [NL];
  logic [3:0]    probe_lane = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // PN status follows the tap currently held by the first swept lane.
  assign pn_err = err_pat[lane_tap[probe_lane]];
  assign pn_oos = oos_pat[lane_tap[probe_lane]];

  axi_ad9361_rx_delay_tune #(
    .NUM_LANES     (NL),
    .TAP_WIDTH     (TW),
    .SETTLE_CYCLES (4),
    .DWELL_CYCLES  (8),
    .MIN_WINDOW    (4)
  ) dut (
    .up_clk       (clk),
    .up_rstn      (up_rstn),
    .start        (start),
    .lane_mask    (lane_mask),
    .delay_locked (delay_locked),
    .up_drdata    (up_drdata),
    .pn_err       (pn_err),
    .pn_oos       (pn_oos),
    .pn_clr       (pn_clr),
    .up_dld       (up_dld),
    .up_dwdata    (up_dwdata),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .lock_err     (lock_err),
    .result_tap   (result_tap),
    .result_len   (result_len)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Brute force: longest clean run starting at each tap; strict > keeps the earliest.
  task automatic ref_window(output int best_len, output int best_start);
    best_len   = 0;
    best_start = 0;
    for (int s = 0; s < NT; s++) begin
      int len = 0;
      while (s + len < NT && !err_pat[s+len] && !oos_pat[s+len]) len++;
      if (len > best_len) begin
        best_len   = len;
        best_start = s;
      end
    end
  endtask

  task automatic set_all(input bit err, input bit oos);
    for (int t = 0; t < NT; t++) begin
      err_pat[t] = err;
      oos_pat[t] = oos;
    end
  endtask

  task automatic make_clean(input int lo, input int hi);
    for (int t = lo; t <= hi; t++) begin
      err_pat[t] = 1'b0;
      oos_pat[t] = 1'b0;
    end
  endtask

  task automatic run_sweep(input string name, input logic [NL-1:0] mask, input bit locked,
                           input int drop_at, input int rst_at, input int repulse_at);
    logic [BW-1:0] orig, exp_lanes, act_lanes;
    int  cyc, loads, exp_len, exp_st, exp_tap;
    bit  ok, seen, data_bad, clash, busy_bad, repulsed, idle_bad;

    probe_lane = '0;
    for (int i = NL - 1; i >= 0; i--) if (mask[i]) probe_lane = 4'(i);
    for (int i = 0; i < NL; i++) orig[i*TW +: TW] = lane_tap[i];
    ref_window(exp_len, exp_st);
    ok      = (exp_len >= 4);
    exp_tap = ok ? exp_st + (exp_len - 1) / 2 : 0;

    @(negedge clk);
    lane_mask    = mask;
    up_drdata    = orig;
    delay_locked = locked;
    start        = 1'b1;
    cyc = 0; loads = 0;
    seen = 0; data_bad = 0; clash = 0; busy_bad = 0; repulsed = 0;

    while (!seen && cyc < SWEEP_CYC + 50) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (repulse_at >= 0 && loads == repulse_at && !repulsed) begin
        start     = 1'b1;
        lane_mask = ~mask;
        repulsed  = 1;
      end
      if (pn_clr && up_dld != '0) clash = 1;
      if (!busy) busy_bad = 1;
      if (up_dld != '0) begin
        if (up_dld != mask) data_bad = 1;
        for (int i = 0; i < NL; i++) begin
          if (!mask[i] && up_dwdata[i*TW +: TW] != orig[i*TW +: TW]) data_bad = 1;
          if (mask[i] && loads < NT && !(drop_at >= 0 && loads > drop_at) &&
              int'(up_dwdata[i*TW +: TW]) != loads) data_bad = 1;
          if (up_dld[i]) lane_tap[i] = up_dwdata[i*TW +: TW];
        end
        loads++;
        if (drop_at >= 0 && loads == drop_at + 1) delay_locked = 1'b0;
        if (rst_at >= 0 && loads == rst_at + 1) begin
          up_rstn = 1'b0;
          @(posedge clk);
          @(negedge clk);
          check({name, "_rst_outputs"},
                {pn_clr, up_dld, up_dwdata, busy, done, fail, lock_err, result_tap, result_len}, '0);
          up_rstn  = 1'b1;
          idle_bad = 0;
          repeat (40) begin
            @(negedge clk);
            if (busy || up_dld != '0 || pn_clr) idle_bad = 1;
          end
          check({name, "_rst_idle"}, idle_bad, 1'b0);
          return;
        end
      end
      if (done) seen = 1;
    end

    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_no_clr_dld_overlap"}, clash, 1'b0);
    check({name, "_busy_held"}, busy_bad, 1'b0);
    check({name, "_load_data"}, data_bad, 1'b0);

    for (int i = 0; i < NL; i++) act_lanes[i*TW +: TW] = lane_tap[i];
    if (!locked) begin
      check({name, "_fail"}, fail, 1'b1);
      check({name, "_lock_err"}, lock_err, 1'b1);
      check({name, "_result_tap"}, result_tap, '0);
      check({name, "_result_len"}, result_len, '0);
      check({name, "_loads"}, loads, 0);
      check({name, "_latency"}, cyc, 2);
      check({name, "_lanes"}, act_lanes, orig);
    end else if (drop_at >= 0) begin
      check({name, "_fail"}, fail, 1'b1);
      check({name, "_lock_err"}, lock_err, 1'b1);
      check({name, "_result_tap"}, result_tap, '0);
      check({name, "_loads"}, loads, drop_at + 2);
      check({name, "_lanes"}, act_lanes, orig);
    end else begin
      for (int i = 0; i < NL; i++)
        exp_lanes[i*TW +: TW] = (ok && mask[i]) ? TW'(exp_tap) : orig[i*TW +: TW];
      check({name, "_fail"}, fail, !ok);
      check({name, "_lock_err"}, lock_err, 1'b0);
      check({name, "_result_tap"}, result_tap, exp_tap);
      check({name, "_result_len"}, result_len, exp_len);
      check({name, "_loads"}, loads, (mask != '0) ? NT + 1 : 0);
      check({name, "_latency"}, cyc, SWEEP_CYC);
      check({name, "_lanes"}, act_lanes, exp_lanes);
    end
    @(negedge clk);
    check({name, "_busy_drop"}, busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NL; i++) lane_tap[i] = TW'(i);
    set_all(1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {pn_clr, up_dld, up_dwdata, busy, done, fail, lock_err, result_tap, result_len}, '0);
    up_rstn = 1'b1;
    repeat (2) @(negedge clk);

    set_all(1'b1, 1'b0);
    make_clean(10, 20);
    run_sweep("s1_centre", 13'h1fff, 1'b1, -1, -1, -1);

    for (int i = 0; i < NL; i++) lane_tap[i] = TW'(i);
    set_all(1'b0, 1'b1);
    run_sweep("s2_all_oos", 13'h1fff, 1'b1, -1, -1, -1);

    set_all(1'b1, 1'b0);
    make_clean(3, 7);
    make_clean(20, 24);
    run_sweep("s3_tie", 13'h1fff, 1'b1, -1, -1, -1);

    set_all(1'b1, 1'b0);
    make_clean(29, 31);
    run_sweep("s3_short", 13'h1fff, 1'b1, -1, -1, -1);

    set_all(1'b0, 1'b0);
    run_sweep("s4_unlocked", 13'h1fff, 1'b0, -1, -1, -1);
    run_sweep("s4_drop", 13'h1fff, 1'b1, 6, -1, -1);

    set_all(1'b1, 1'b0);
    make_clean(10, 20);
    run_sweep("s5_mask1", 13'h0001, 1'b1, -1, -1, 3);

    set_all(1'b0, 1'b0);
    run_sweep("mask0", 13'h0000, 1'b1, -1, -1, -1);

    run_sweep("s6_reset", 13'h1fff, 1'b1, -1, 10, -1);
    run_sweep("s6_after", 13'h1fff, 1'b1, -1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      int lo, len;
      for (int t = 0; t < NT; t++) begin
        err_pat[t] = ($urandom_range(0, 99) < 20);
        oos_pat[t] = ($urandom_range(0, 99) < 8);
      end
      lo  = $urandom_range(0, NT - 1);
      len = $urandom_range(0, 12);
      if (len > 0) make_clean(lo, (lo + len - 1 < NT) ? lo + len - 1 : NT - 1);
      for (int i = 0; i < NL; i++) lane_tap[i] = TW'($urandom_range(0, NT - 1));
      run_sweep($sformatf("rand%0d", r), NL'($urandom_range(1, (1 << NL) - 1)), 1'b1, -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
